// File: rtl/is_pkg_uart_controller.sv
// is_pkg_uart_controller: shared widths and arbiter state encoding for the UART controller
package is_pkg_uart_controller;
  localparam int DATA_W   = 8;
  localparam int TX_CNT_W = 16;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LAUNCH  = 3'd1,
    WAIT_LO = 3'd2,
    WAIT_HI = 3'd3,
    ACK     = 3'd4
  } arb_state_e;
endpackage

// File: rtl/is_rr_pick.sv
// is_rr_pick: combinational round-robin picker, first requester after the last-served index
module is_rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          vld_o
);
  // scan offsets from farthest to nearest so the nearest requester after last_i wins
  always_comb begin
    int k;
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    for (int i = N; i >= 1; i--) begin
      k = (int'(last_i) + i) % N;
      if (req_i[k]) begin
        gnt_o    = '0;
        gnt_o[k] = 1'b1;
        idx_o    = IW'(k);
        vld_o    = 1'b1;
      end
    end
  end
endmodule

// File: rtl/is_uart_tx_arbiter.sv
// is_uart_tx_arbiter: round-robin sharing of one UART TX FSM; IS_UART_TX_ARB_TIMEOUT_EN adds a done timeout and err_o
module is_uart_tx_arbiter
  import is_pkg_uart_controller::*;
#(
  parameter int N_CLIENTS = 4
`ifdef IS_UART_TX_ARB_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 65535
`endif
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic [N_CLIENTS-1:0]          req_i,
  input  logic [N_CLIENTS*DATA_W-1:0]   data_i,
  output logic [N_CLIENTS-1:0]          ack_o,
  output logic [N_CLIENTS-1:0]          grant_o,
  output logic                          tx_rdy_t_o,
  output logic [DATA_W-1:0]             tx_data_r_o,
  input  logic                          tx_rdy_r_i,
  output logic                          busy_o,
  output logic [TX_CNT_W-1:0]           tx_cnt_o
`ifdef IS_UART_TX_ARB_TIMEOUT_EN
  , output logic                        err_o
`endif
);
  localparam int IW = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
  arb_state_e            state_q, state_d;
  logic [N_CLIENTS-1:0]  grant_q, grant_d, pick_gnt;
  logic [IW-1:0]         ptr_q, ptr_d, own_q, own_d, pick_idx;
  logic                  pick_vld, start_q, wait_st;
  logic [DATA_W-1:0]     data_q, data_d;
  logic [TX_CNT_W-1:0]   cnt_q, cnt_d;
`ifdef IS_UART_TX_ARB_TIMEOUT_EN
  logic [31:0]           tmo_q, tmo_d;
  logic                  to_q, to_d, err_q, err_d;
`endif

  is_rr_pick #(.N(N_CLIENTS), .IW(IW)) u_pick (
    .req_i (req_i),
    .last_i(ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .vld_o (pick_vld)
  );

  assign wait_st = (state_q == WAIT_LO) || (state_q == WAIT_HI);

  // next-state: grant and latch in IDLE, follow the transmitter ready level, retire in ACK
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    own_d   = own_q;
    data_d  = data_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
`ifdef IS_UART_TX_ARB_TIMEOUT_EN
    tmo_d   = wait_st ? tmo_q + 32'd1 : '0;
    to_d    = to_q;
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: if (pick_vld) begin
        grant_d = pick_gnt;
        own_d   = pick_idx;
        data_d  = data_i[int'(pick_idx)*DATA_W +: DATA_W];
        state_d = LAUNCH;
      end
      LAUNCH:  state_d = WAIT_LO;
      WAIT_LO: state_d = tx_rdy_r_i ? WAIT_LO : WAIT_HI;
      WAIT_HI: state_d = tx_rdy_r_i ? ACK : WAIT_HI;
      ACK: begin
        ptr_d   = own_q;
        grant_d = '0;
        state_d = IDLE;
`ifdef IS_UART_TX_ARB_TIMEOUT_EN
        cnt_d   = to_q ? cnt_q : cnt_q + TX_CNT_W'(1);
        to_d    = 1'b0;
`else
        cnt_d   = cnt_q + TX_CNT_W'(1);
`endif
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
`ifdef IS_UART_TX_ARB_TIMEOUT_EN
    if (wait_st && tmo_q == 32'(TIMEOUT_CYC - 1)) begin
      state_d = ACK;
      to_d    = 1'b1;
      err_d   = 1'b1;
    end
`endif
  end

  // state and datapath registers; start pulse is registered from the LAUNCH state
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      own_q   <= '0;
      data_q  <= '0;
      ptr_q   <= IW'(N_CLIENTS - 1);
      cnt_q   <= '0;
      start_q <= 1'b0;
`ifdef IS_UART_TX_ARB_TIMEOUT_EN
      tmo_q   <= '0;
      to_q    <= 1'b0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      own_q   <= own_d;
      data_q  <= data_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      start_q <= state_q == LAUNCH;
`ifdef IS_UART_TX_ARB_TIMEOUT_EN
      tmo_q   <= tmo_d;
      to_q    <= to_d;
      err_q   <= err_d;
`endif
    end
  end

  assign ack_o       = (state_q == ACK) ? grant_q : '0;
  assign grant_o     = grant_q;
  assign tx_rdy_t_o  = start_q;
  assign tx_data_r_o = data_q;
  assign busy_o      = state_q != IDLE;
  assign tx_cnt_o    = cnt_q;
`ifdef IS_UART_TX_ARB_TIMEOUT_EN
  assign err_o       = err_q;
`endif
endmodule

// File: tb/tb_is_uart_tx_arbiter.sv
// tb_is_uart_tx_arbiter: directed self-checking bench for is_uart_tx_arbiter
module tb_is_uart_tx_arbiter;
  localparam int D1 =
`ifdef IS_UART_TX_ARB_TIMEOUT_EN
    90;
`else
    110;
`endif
  logic        clk = 0;
  logic        rstn = 0;
  logic [3:0]  req = '0;
  logic [31:0] data = '0;
  logic [3:0]  ack, grant;
  logic        tx_rdy_t, busy;
  logic [7:0]  tx_data;
  logic [15:0] tx_cnt;
  logic        rdy = 0;
  int          dly = 3;
  bit          hang = 0;
  int          cnt_m = 0;
  int          n_chk = 0;
  int          n_err = 0;
  int          c;
  logic [3:0]  a;
  logic        seen;
`ifdef IS_UART_TX_ARB_TIMEOUT_EN
  logic        err;
`endif

  always #5 clk = ~clk;

  is_uart_tx_arbiter #(
    .N_CLIENTS(4)
`ifdef IS_UART_TX_ARB_TIMEOUT_EN
    , .TIMEOUT_CYC(100)
`endif
  ) dut (
    .clk_i      (clk),
    .rstn_i     (rstn),
    .req_i      (req),
    .data_i     (data),
    .ack_o      (ack),
    .grant_o    (grant),
    .tx_rdy_t_o (tx_rdy_t),
    .tx_data_r_o(tx_data),
    .tx_rdy_r_i (rdy),
    .busy_o     (busy),
    .tx_cnt_o   (tx_cnt)
`ifdef IS_UART_TX_ARB_TIMEOUT_EN
    , .err_o    (err)
`endif
  );

  // transmitter model: ready resets low, drops the edge after start, rises dly edges later
  always @(posedge clk) begin
    if (!rstn) begin
      rdy   <= 1'b0;
      cnt_m <= 0;
    end else if (tx_rdy_t) begin
      rdy   <= 1'b0;
      cnt_m <= dly;
    end else if (cnt_m != 0) begin
      cnt_m <= cnt_m - 1;
      if (cnt_m == 1 && !hang) rdy <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic rst_dut();
    @(negedge clk);
    rstn = 0;
    req  = '0;
    repeat (2) @(negedge clk);
    rstn = 1;
  endtask

  task automatic wait_ack(input int lim, output int cyc, output logic [3:0] got);
    got = '0;
    cyc = 0;
    while (got == 0 && cyc < lim) begin
      @(negedge clk);
      cyc++;
      got = ack;
    end
    chk("ack_seen", 32'(got != 0), 1);
  endtask

  initial begin
    rst_dut();
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", tx_cnt, 0);
    chk("rst_start", tx_rdy_t, 0);
    chk("rst_ack", ack, 0);
    chk("rst_data", tx_data, 0);

    dly = D1;
    data[7:0] = 8'h55;
    req = 4'b0001;
    @(negedge clk);
    chk("t1_grant", grant, 4'b0001);
    chk("t1_start_early", tx_rdy_t, 0);
    chk("t1_busy", busy, 1);
    @(negedge clk);
    chk("t1_start", tx_rdy_t, 1);
    chk("t1_data", tx_data, 8'h55);
    @(negedge clk);
    chk("t1_start_end", tx_rdy_t, 0);
    wait_ack(400, c, a);
    req = '0;
    chk("t1_ack_lat", c, D1 + 1);
    chk("t1_ack", a, 4'b0001);
    @(negedge clk);
    chk("t1_ack_pulse", ack, 0);
    chk("t1_cnt", tx_cnt, 1);
    chk("t1_idle", busy, 0);

    rst_dut();
    dly = 3;
    for (int k = 0; k < 4; k++) data[k*8 +: 8] = 8'(8'h10 + k);
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_ack(100, c, a);
      if (i == 4) req = '0;
      chk("rr_ack", a, 4'b0001 << (i % 4));
      chk("rr_grant", grant, 4'b0001 << (i % 4));
      chk("rr_data", tx_data, 8'h10 + (i % 4));
    end
    repeat (2) @(negedge clk);
    chk("rr_cnt", tx_cnt, 5);
    chk("rr_idle", busy, 0);

    rst_dut();
    req = 4'b0010;
    wait_ack(100, c, a);
    req = '0;
    chk("ptr_first", a, 4'b0010);
    @(negedge clk);
    req = 4'b0011;
    @(negedge clk);
    chk("ptr_grant", grant, 4'b0001);
    wait_ack(100, c, a);
    req = '0;
    chk("ptr_ack", a, 4'b0001);

    @(negedge clk);
    data[23:16] = 8'h42;
    req = 4'b0100;
    @(negedge clk);
    chk("drop_grant", grant, 4'b0100);
    repeat (3) @(negedge clk);
    req = '0;
    data[23:16] = 8'hFF;
    wait_ack(100, c, a);
    chk("drop_ack", a, 4'b0100);
    chk("drop_data", tx_data, 8'h42);
    @(negedge clk);
    chk("drop_cnt", tx_cnt, 3);

    dly = 50;
    req = 4'b0001;
    @(negedge clk);
    req = '0;
    repeat (10) @(negedge clk);
    chk("mid_busy", busy, 1);
    chk("mid_cnt", tx_cnt, 3);
    rstn = 0;
    @(negedge clk);
    chk("mid_grant", grant, 0);
    chk("mid_busy_rst", busy, 0);
    chk("mid_cnt_rst", tx_cnt, 0);
    chk("mid_ack", ack, 0);
    rstn = 1;
    seen = 0;
    repeat (60) begin
      @(negedge clk);
      seen |= (ack != 0);
    end
    chk("mid_no_ack", seen, 0);

`ifdef IS_UART_TX_ARB_TIMEOUT_EN
    rst_dut();
    hang = 1;
    req = 4'b0001;
    wait_ack(300, c, a);
    req = '0;
    chk("to_lat", c, 102);
    chk("to_ack", a, 4'b0001);
    chk("to_err", err, 1);
    @(negedge clk);
    chk("to_cnt", tx_cnt, 0);
    repeat (5) @(negedge clk);
    chk("to_err_sticky", err, 1);
    hang = 0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
